// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: synchronizes rx_serial, samples each bit at mid-period,
// and holds one byte behind a valid/ack handshake with overrun and framing-error flags.
module uart_rx_byte #(
    parameter int CLKS_PER_BIT = 434,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rx_serial,
    input  logic       rx_ack,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_overrun,
    output logic       rx_frame_error,
    output logic       rx_busy
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_START     = 3'd1;
    localparam logic [2:0] S_DATA      = 3'd2;
    localparam logic [2:0] S_STOP      = 3'd3;
    localparam logic [2:0] S_WAIT_HIGH = 3'd4;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_rx_prev;
    logic [2:0]             r_state;
    logic [CW-1:0]          r_cnt;
    logic [2:0]             r_idx;
    logic [7:0]             r_shift;
    logic                   r_load;
    logic [7:0]             r_data;
    logic                   r_valid;
    logic                   r_overrun;
    logic                   r_frame_error;
    logic                   r_busy;

    logic       w_rx_s;
    logic       w_fall;
    logic       w_cnt_zero;
    logic [2:0] w_state_nxt;
    logic       w_stop_good;
    logic       w_stop_bad;

    assign w_rx_s     = r_sync[SYNC_STAGES-1];
    assign w_fall     = r_rx_prev & ~w_rx_s;
    assign w_cnt_zero = (r_cnt == '0);

    // Synchronizer idles high so reset release never looks like a start edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync    <= '1;
            r_rx_prev <= 1'b1;
        end else begin
            r_sync    <= {r_sync[SYNC_STAGES-2:0], rx_serial};
            r_rx_prev <= w_rx_s;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_stop_good = 1'b0;
        w_stop_bad  = 1'b0;
        case (r_state)
            S_IDLE:  if (w_fall) w_state_nxt = S_START;
            S_START: if (w_cnt_zero) w_state_nxt = w_rx_s ? S_IDLE : S_DATA;
            S_DATA:  if (w_cnt_zero && r_idx == 3'd7) w_state_nxt = S_STOP;
            S_STOP: begin
                if (w_cnt_zero) begin
                    if (w_rx_s) begin
                        w_stop_good = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_stop_bad  = 1'b1;
                        w_state_nxt = S_WAIT_HIGH;
                    end
                end
            end
            S_WAIT_HIGH: if (w_rx_s) w_state_nxt = S_IDLE;
            default:     w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt != S_IDLE);
            case (r_state)
                S_IDLE: if (w_fall) r_cnt <= HALF_M1;
                S_START: begin
                    if (!w_cnt_zero) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else if (!w_rx_s) begin
                        r_cnt <= FULL_M1;
                        r_idx <= '0;
                    end
                end
                S_DATA: begin
                    if (w_cnt_zero) begin
                        r_shift[r_idx] <= w_rx_s;
                        r_cnt          <= FULL_M1;
                        r_idx          <= r_idx + 3'd1;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_STOP:  if (!w_cnt_zero) r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Byte is committed the cycle after the stop sample; a coincident ack loses to the load.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_load        <= 1'b0;
            r_frame_error <= 1'b0;
            r_data        <= '0;
            r_valid       <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            r_load        <= w_stop_good;
            r_frame_error <= w_stop_bad;
            if (r_load) begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
                if (r_valid && !rx_ack) r_overrun <= 1'b1;
                else if (rx_ack)        r_overrun <= 1'b0;
            end else if (rx_ack) begin
                r_valid   <= 1'b0;
                r_overrun <= 1'b0;
            end
        end
    end

    assign rx_data        = r_data;
    assign rx_valid       = r_valid;
    assign rx_overrun     = r_overrun;
    assign rx_frame_error = r_frame_error;
    assign rx_busy        = r_busy;
endmodule

// File: tb/tb_uart_rx_byte.sv
// Bench for uart_rx_byte at 16 clk/bit: directed scenarios plus randomized frames
// checked against a handshake-level model of the byte holder.
module tb_uart_rx_byte;
    localparam int CPB = 16;
    localparam int SS  = 2;
    localparam int LAT = SS + 1 + CPB / 2 + 9 * CPB;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       rx_serial = 1'b1;
    logic       rx_ack = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid, rx_overrun, rx_frame_error, rx_busy;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int t_drive = 0;
    int t_rise = -1;
    int rise_cnt = 0;
    int fe_cnt = 0;
    logic vprev = 1'b0;

    // Reference model of the byte holder
    logic [7:0] m_data = 8'h00;
    logic       m_valid = 1'b0;
    logic       m_overrun = 1'b0;

    uart_rx_byte #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(SS)) dut (
        .clk(clk), .reset_n(reset_n), .rx_serial(rx_serial), .rx_ack(rx_ack),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_overrun(rx_overrun),
        .rx_frame_error(rx_frame_error), .rx_busy(rx_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        cyc++;
        if (rx_valid && !vprev) begin
            t_rise = cyc;
            rise_cnt++;
        end
        vprev = rx_valid;
        if (rx_frame_error) fe_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    // Caller must be at a negedge; leaves the line at the stop-bit level.
    task automatic send_frame(input logic [7:0] b, input bit stop_ok);
        rx_serial = 1'b0;
        t_drive = cyc;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_serial = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx_serial = stop_ok;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic model_good(input logic [7:0] b, input bit ack_at_load);
        if (m_valid && !ack_at_load) m_overrun = 1'b1;
        else if (ack_at_load)        m_overrun = 1'b0;
        m_valid = 1'b1;
        m_data  = b;
    endtask

    task automatic pulse_ack();
        rx_ack = 1'b1;
        @(negedge clk);
        rx_ack = 1'b0;
        if (m_valid) begin
            m_valid = 1'b0;
            m_overrun = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (rx_data !== 8'h00) begin n_err++; $display("FAIL reset_data got=%h exp=00", rx_data); end
        n_cmp++; if (rx_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b exp=0", rx_valid); end
        n_cmp++; if (rx_overrun !== 1'b0) begin n_err++; $display("FAIL reset_overrun got=%b exp=0", rx_overrun); end
        n_cmp++; if (rx_frame_error !== 1'b0) begin n_err++; $display("FAIL reset_ferr got=%b exp=0", rx_frame_error); end
        n_cmp++; if (rx_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", rx_busy); end
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_single();
        int fe0, d;
        fe0 = fe_cnt;
        t_rise = -1;
        send_frame(8'hA5, 1'b1);
        rx_serial = 1'b1;
        model_good(8'hA5, 1'b0);
        repeat (4) @(negedge clk);
        d = (t_rise < 0) ? -1 : t_rise - t_drive;
        n_cmp++; if (d < LAT || d > LAT + 2) begin n_err++; $display("FAIL single_latency got=%0d exp=%0d..%0d", d, LAT, LAT + 2); end
        n_cmp++; if (rx_data !== m_data) begin n_err++; $display("FAIL single_data got=%h exp=%h", rx_data, m_data); end
        n_cmp++; if (rx_valid !== m_valid) begin n_err++; $display("FAIL single_valid got=%b exp=%b", rx_valid, m_valid); end
        n_cmp++; if (rx_overrun !== m_overrun) begin n_err++; $display("FAIL single_overrun got=%b exp=%b", rx_overrun, m_overrun); end
        n_cmp++; if (fe_cnt !== fe0) begin n_err++; $display("FAIL single_ferr got=%0d exp=%0d", fe_cnt - fe0, 0); end
        pulse_ack();
        n_cmp++; if (rx_valid !== 1'b0) begin n_err++; $display("FAIL single_ack_valid got=%b exp=0", rx_valid); end
    endtask

    task automatic test_glitch();
        int fe0, r0;
        logic saw_busy;
        fe0 = fe_cnt;
        r0 = rise_cnt;
        saw_busy = 1'b0;
        rx_serial = 1'b0;
        for (int i = 0; i < CPB; i++) begin
            if (i == 4) rx_serial = 1'b1;
            @(negedge clk);
            saw_busy |= rx_busy;
        end
        n_cmp++; if (saw_busy !== 1'b1) begin n_err++; $display("FAIL glitch_busy_rise got=%b exp=1", saw_busy); end
        n_cmp++; if (rx_busy !== 1'b0) begin n_err++; $display("FAIL glitch_busy_end got=%b exp=0", rx_busy); end
        n_cmp++; if (rx_valid !== 1'b0 || rise_cnt !== r0) begin n_err++; $display("FAIL glitch_valid got=%b exp=0", rx_valid); end
        n_cmp++; if (fe_cnt !== fe0) begin n_err++; $display("FAIL glitch_ferr got=%0d exp=0", fe_cnt - fe0); end
    endtask

    task automatic test_frame_error();
        int fe0, r0, idle_seen;
        fe0 = fe_cnt;
        r0 = rise_cnt;
        idle_seen = 0;
        send_frame(8'h3C, 1'b0);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!rx_busy) idle_seen++;
        end
        rx_serial = 1'b1;
        repeat (5) @(negedge clk);
        n_cmp++; if (idle_seen !== 0) begin n_err++; $display("FAIL ferr_wait_high idle_cycles got=%0d exp=0", idle_seen); end
        n_cmp++; if (fe_cnt - fe0 !== 1) begin n_err++; $display("FAIL ferr_pulses got=%0d exp=1", fe_cnt - fe0); end
        n_cmp++; if (rx_data !== m_data) begin n_err++; $display("FAIL ferr_data got=%h exp=%h", rx_data, m_data); end
        n_cmp++; if (rx_valid !== m_valid || rise_cnt !== r0) begin n_err++; $display("FAIL ferr_valid got=%b exp=%b", rx_valid, m_valid); end
        n_cmp++; if (rx_busy !== 1'b0) begin n_err++; $display("FAIL ferr_busy_end got=%b exp=0", rx_busy); end
    endtask

    task automatic test_overrun();
        send_frame(8'h11, 1'b1);
        model_good(8'h11, 1'b0);
        send_frame(8'h22, 1'b1);
        model_good(8'h22, 1'b0);
        rx_serial = 1'b1;
        repeat (4) @(negedge clk);
        n_cmp++; if (rx_data !== m_data) begin n_err++; $display("FAIL ovr_data got=%h exp=%h", rx_data, m_data); end
        n_cmp++; if (rx_valid !== m_valid) begin n_err++; $display("FAIL ovr_valid got=%b exp=%b", rx_valid, m_valid); end
        n_cmp++; if (rx_overrun !== m_overrun) begin n_err++; $display("FAIL ovr_overrun got=%b exp=%b", rx_overrun, m_overrun); end
        pulse_ack();
        n_cmp++; if (rx_valid !== 1'b0 || rx_overrun !== 1'b0) begin n_err++; $display("FAIL ovr_ack got=%b%b exp=00", rx_valid, rx_overrun); end
    endtask

    task automatic test_sim_ack();
        send_frame(8'h55, 1'b1);
        model_good(8'h55, 1'b0);
        fork
            send_frame(8'h7E, 1'b1);
            begin
                repeat (LAT) @(negedge clk);
                rx_ack = 1'b1;
                @(negedge clk);
                rx_ack = 1'b0;
            end
        join
        model_good(8'h7E, 1'b1);
        rx_serial = 1'b1;
        repeat (4) @(negedge clk);
        n_cmp++; if (rx_valid !== m_valid) begin n_err++; $display("FAIL simack_valid got=%b exp=%b", rx_valid, m_valid); end
        n_cmp++; if (rx_data !== m_data) begin n_err++; $display("FAIL simack_data got=%h exp=%h", rx_data, m_data); end
        n_cmp++; if (rx_overrun !== m_overrun) begin n_err++; $display("FAIL simack_overrun got=%b exp=%b", rx_overrun, m_overrun); end
    endtask

    // Leaves the 0x7E byte unconsumed so the reset visibly clears it.
    task automatic test_reset_mid();
        int r0;
        rx_serial = 1'b0;
        repeat (CPB) @(negedge clk);
        rx_serial = 1'b1;
        repeat (3 * CPB + CPB / 2) @(negedge clk);
        reset_n = 1'b0;
        #1;
        n_cmp++; if (rx_data !== 8'h00 || rx_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_data_valid got=%h/%b exp=00/0", rx_data, rx_valid); end
        n_cmp++; if (rx_busy !== 1'b0 || rx_overrun !== 1'b0 || rx_frame_error !== 1'b0) begin n_err++; $display("FAIL rstmid_flags got=%b%b%b exp=000", rx_busy, rx_overrun, rx_frame_error); end
        m_data = 8'h00; m_valid = 1'b0; m_overrun = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        r0 = rise_cnt;
        repeat (12 * CPB) @(negedge clk);
        n_cmp++; if (rx_valid !== 1'b0 || rise_cnt !== r0) begin n_err++; $display("FAIL rstmid_no_byte got=%b exp=0", rx_valid); end
        send_frame(8'h81, 1'b1);
        model_good(8'h81, 1'b0);
        rx_serial = 1'b1;
        repeat (4) @(negedge clk);
        n_cmp++; if (rx_data !== m_data || rx_valid !== m_valid) begin n_err++; $display("FAIL rstmid_after got=%h/%b exp=%h/%b", rx_data, rx_valid, m_data, m_valid); end
    endtask

    task automatic test_random();
        logic [7:0] b;
        for (int k = 0; k < 8; k++) begin
            if ($urandom_range(1, 0) == 1) pulse_ack();
            b = 8'($urandom);
            send_frame(b, 1'b1);
            model_good(b, 1'b0);
            rx_serial = 1'b1;
            repeat ($urandom_range(3, 0)) @(negedge clk);
            if ($urandom_range(1, 0) == 1) begin
                repeat (3) @(negedge clk);
                n_cmp++; if (rx_data !== m_data) begin n_err++; $display("FAIL rand_data[%0d] got=%h exp=%h", k, rx_data, m_data); end
                n_cmp++; if (rx_valid !== m_valid || rx_overrun !== m_overrun) begin n_err++; $display("FAIL rand_flags[%0d] got=%b%b exp=%b%b", k, rx_valid, rx_overrun, m_valid, m_overrun); end
            end
        end
        repeat (3) @(negedge clk);
        n_cmp++; if (rx_data !== m_data) begin n_err++; $display("FAIL rand_final_data got=%h exp=%h", rx_data, m_data); end
        n_cmp++; if (rx_valid !== m_valid || rx_overrun !== m_overrun) begin n_err++; $display("FAIL rand_final_flags got=%b%b exp=%b%b", rx_valid, rx_overrun, m_valid, m_overrun); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single();
        test_glitch();
        test_frame_error();
        test_overrun();
        test_sim_ack();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/uart_rx_byte.md
Name: uart_rx_byte

Overview:
- UART receiver: recovers 8N1 serial frames from the UART_RXD pin and presents bytes to the processor's memory-mapped I/O block.
- It is the receive-side counterpart to the processor's serial transmitter, and the board top level instantiates it in the 50 MHz clock domain.
- It holds one received byte with a valid/acknowledge handshake, and reports framing errors and overrun.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per bit period (50 MHz / 115200 baud). Must be ≥ 8.
- SYNC_STAGES, 2, number of input synchronizer flops. Must be ≥ 2.

Ports:
- clk, input, 1: system clock (CLOCK_50 at the top level).
- reset_n, input, 1: asynchronous active-low reset.
- rx_serial, input, 1: asynchronous serial line; idles high.
- rx_ack, input, 1: one-cycle pulse from the consumer; clears rx_valid and rx_overrun.
- rx_data, output, 8: last good received byte.
- rx_valid, output, 1: rx_data holds an unconsumed byte.
- rx_overrun, output, 1: sticky; a good byte arrived while rx_valid=1.
- rx_frame_error, output, 1: one-cycle pulse; the stop bit was sampled low.
- rx_busy, output, 1: the receiver is inside a frame (state ≠ IDLE).

Behaviour:
- Reset (async assert, sync release):
  - rx_data=0x00, rx_valid=0, rx_overrun=0, rx_frame_error=0, rx_busy=0.
  - Synchronizer flops reset to 1; state=IDLE; counters=0.
  - Reset asserted mid-frame aborts the frame with no output.
- Synchronizer: rx_serial passes through SYNC_STAGES flops. All logic below uses the synchronized signal rx_s, and edge detection compares rx_s to its previous value.
- States: IDLE, START, DATA, STOP, WAIT_HIGH.
- IDLE: on a falling edge of rx_s, go to START and load the bit counter with CLKS_PER_BIT/2 − 1 (integer division).
- START: count down to 0, then sample rx_s at mid start bit.
  - rx_s=1: treat as a glitch and return to IDLE with no output.
  - rx_s=0: go to DATA; bit index=0; counter=CLKS_PER_BIT−1.
- DATA: each time the counter reaches 0, sample rx_s into shift-register bit[index] (LSB first) and reload the counter with CLKS_PER_BIT−1. After index 7 is sampled, go to STOP.
- STOP: when the counter reaches 0, sample rx_s.
  - rx_s=1: take the good-byte path (below) and go to IDLE.
  - rx_s=0: pulse rx_frame_error for exactly one cycle, discard the byte (rx_data, rx_valid unchanged), and go to WAIT_HIGH.
- WAIT_HIGH: stay until rx_s=1, then go to IDLE. This prevents a break condition from retriggering a start.
- Good-byte path, in the cycle after the stop sample:
  - rx_data ← shift register; rx_valid ← 1.
  - If rx_valid was already 1 and rx_ack is not asserted in that same cycle, set rx_overrun ← 1. The new byte overwrites the old one.
- rx_ack handling: rx_ack clears rx_valid and rx_overrun in the next cycle.
  - If rx_ack coincides with the good-byte load cycle, the load wins: rx_valid stays 1 and rx_overrun is not set.
  - rx_ack while rx_valid=0 has no effect.
- Latency: rx_valid rises exactly SYNC_STAGES + 1 + (CLKS_PER_BIT/2) + 9·CLKS_PER_BIT cycles after the first clk edge that samples rx_serial low, tolerance ±1 cycle.
- Back-to-back frames: a start edge is accepted in the first IDLE cycle after STOP. There is no minimum idle time beyond the stop bit.
- rx_busy = (state ≠ IDLE), registered.

Test Plan (CLKS_PER_BIT=16 for simulation):
- Single byte: send 0xA5 at 16 clk/bit, then idle → rx_valid rises within latency ±1; rx_data=0xA5; rx_overrun=0; no rx_frame_error pulse. Then rx_ack → rx_valid=0 in the next cycle.
- Glitch: drive rx_serial low for 4 cycles, then high → rx_busy rises then returns to 0 within 16 cycles; rx_valid stays 0; no error.
- Framing error: send 0x3C with the stop bit low, then hold the line low for 40 cycles, then high → exactly one rx_frame_error pulse; rx_data unchanged; state remains WAIT_HIGH until the line goes high; no new frame starts during the low hold.
- Overrun: send 0x11 then 0x22 back-to-back with no ack → rx_data=0x22, rx_valid=1, rx_overrun=1. Then rx_ack → both clear.
- Simultaneous ack: assert rx_ack in the exact load cycle of a second byte 0x7E → rx_valid=1, rx_data=0x7E, rx_overrun=0.
- Reset mid-frame: assert reset_n=0 during DATA bit 3 of 0xFF → all outputs return to reset values immediately. After release, with the line idle, no byte appears. Then send 0x81 → rx_data=0x81.
